up_down_counter: RTL and testbench



---
 rtl/up_down_counter_pkg.sv | 8 +
 rtl/up_down_counter_if.sv | 15 +
 rtl/up_down_counter_next.sv | 32 +++
 rtl/up_down_counter.sv | 33 +++
 tb/tb_up_down_counter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg: shared width default and direction encoding for the counter
package up_down_counter_pkg;
    localparam int CNT_WIDTH_DEF = 4;
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;
endpackage

// File: rtl/up_down_counter_if.sv
// up_down_counter_if: bundled counter signals
//   load_en, load, down : controller -> counter
//   count, rollover     : counter -> controller
//   master modport = controller side, slave modport = counter side
interface up_down_counter_if #(
    parameter int WIDTH = up_down_counter_pkg::CNT_WIDTH_DEF
);
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             rollover;
    modport master (output load_en, load, down, input count, rollover);
    modport slave (input load_en, load, down, output count, rollover);
endinterface

// File: rtl/up_down_counter_next.sv
// up_down_counter_next: combinational next count value and wrap/saturation flag
//   count     : current value
//   down      : 0 increments, 1 decrements
//   load_en   : a load this cycle suppresses the flag
//   next_count: counted value (wrapping, or held at the limit when UP_DOWN_COUNTER_SAT_EN is defined)
//   wrap_flag : wrap event, or blocked count in saturation mode
module up_down_counter_next
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] count,
    input  logic             down,
    input  logic             load_en,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_flag
);
    dir_e dir;
    logic at_limit;
    assign dir = dir_e'(down);
    // the value at which the current direction wraps or saturates
    assign at_limit = (dir == DIR_DN) ? ~|count : &count;
    always_comb begin
`ifdef UP_DOWN_COUNTER_SAT_EN
        next_count = at_limit ? count
                   : (dir == DIR_DN) ? count - WIDTH'(1) : count + WIDTH'(1);
`else
        next_count = (dir == DIR_DN) ? count - WIDTH'(1) : count + WIDTH'(1);
`endif
        wrap_flag = !load_en && at_limit;
    end
endmodule

// File: rtl/up_down_counter.sv
// up_down_counter: loadable up/down counter with registered wrap pulse
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset, clears count and rollover
//   bus  : slave side of up_down_counter_if (load_en, load, down in; count, rollover out)
//   UP_DOWN_COUNTER_SAT_EN: when defined, counts saturate and rollover flags blocked counts
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input logic                clk,
    input logic                rstn,
    up_down_counter_if.slave   bus
);
    logic [WIDTH-1:0] next_count;
    logic             wrap_flag;
    up_down_counter_next #(.WIDTH(WIDTH)) u_next (
        .count      (bus.count),
        .down       (bus.down),
        .load_en    (bus.load_en),
        .next_count (next_count),
        .wrap_flag  (wrap_flag)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.count    <= '0;
            bus.rollover <= 1'b0;
        end else begin
            bus.count    <= bus.load_en ? bus.load : next_count;
            bus.rollover <= wrap_flag;
        end
    end
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed self-checking bench for up_down_counter
module tb_up_down_counter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    up_down_counter_if #(.WIDTH(4)) bus ();

    up_down_counter #(.WIDTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic le, input logic [3:0] ld, input logic dn);
        bus.load_en = le;
        bus.load    = ld;
        bus.down    = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_c [2] = '{4'h1, 4'h2};
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'hA, 1'b0);
            checks++;
            if (bus.count !== 4'h0 || bus.rollover !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d] count=%h rollover=%b expected count=0 rollover=0", i, bus.count, bus.rollover);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'hA, 1'b0);
            checks++;
            if (bus.count !== exp_c[i] || bus.rollover !== 1'b0) begin
                failures++;
                $display("FAIL reset_release[%0d] count=%h rollover=%b expected count=%h rollover=0", i, bus.count, bus.rollover, exp_c[i]);
            end
        end
    endtask

    task automatic test_up_wrap();
`ifdef UP_DOWN_COUNTER_SAT_EN
        logic [3:0] exp_c [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic [3:0] exp_c [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 4'hE, 1'b0);
            checks++;
            if (bus.count !== exp_c[i] || bus.rollover !== exp_r[i]) begin
                failures++;
                $display("FAIL up_wrap[%0d] count=%h rollover=%b expected count=%h rollover=%b", i, bus.count, bus.rollover, exp_c[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
`ifdef UP_DOWN_COUNTER_SAT_EN
        logic [3:0] exp_c [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic [3:0] exp_c [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 4'h1, 1'b1);
            checks++;
            if (bus.count !== exp_c[i] || bus.rollover !== exp_r[i]) begin
                failures++;
                $display("FAIL down_wrap[%0d] count=%h rollover=%b expected count=%h rollover=%b", i, bus.count, bus.rollover, exp_c[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h3, 1'b1);
        checks++;
        if (bus.count !== 4'h3 || bus.rollover !== 1'b0) begin
            failures++;
            $display("FAIL load_over_down count=%h rollover=%b expected count=3 rollover=0", bus.count, bus.rollover);
        end
        drive(1'b1, 4'hF, 1'b0);
        drive(1'b1, 4'h0, 1'b0);
        checks++;
        if (bus.count !== 4'h0 || bus.rollover !== 1'b0) begin
            failures++;
            $display("FAIL load_zero_at_max count=%h rollover=%b expected count=0 rollover=0", bus.count, bus.rollover);
        end
        drive(1'b1, 4'h9, 1'b0);
        drive(1'b1, 4'h9, 1'b0);
        checks++;
        if (bus.count !== 4'h9 || bus.rollover !== 1'b0) begin
            failures++;
            $display("FAIL load_same_value count=%h rollover=%b expected count=9 rollover=0", bus.count, bus.rollover);
        end
    endtask

    task automatic test_direction_toggle();
        logic [3:0] exp_c [4] = '{4'h8, 4'h7, 4'h8, 4'h7};
        drive(1'b1, 4'h7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h0, logic'(i % 2));
            checks++;
            if (bus.count !== exp_c[i] || bus.rollover !== 1'b0) begin
                failures++;
                $display("FAIL dir_toggle[%0d] count=%h rollover=%b expected count=%h rollover=0", i, bus.count, bus.rollover, exp_c[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 4'hF, 1'b0);
        rstn = 1'b0;
        drive(1'b0, 4'h0, 1'b0);
        checks++;
        if (bus.count !== 4'h0 || bus.rollover !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset count=%h rollover=%b expected count=0 rollover=0", bus.count, bus.rollover);
        end
        rstn = 1'b1;
        drive(1'b0, 4'h0, 1'b1);
        checks++;
`ifdef UP_DOWN_COUNTER_SAT_EN
        if (bus.count !== 4'h0 || bus.rollover !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_down count=%h rollover=%b expected count=0 rollover=1", bus.count, bus.rollover);
        end
`else
        if (bus.count !== 4'hF || bus.rollover !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_down count=%h rollover=%b expected count=f rollover=1", bus.count, bus.rollover);
        end
`endif
    endtask

    initial begin
        bus.load_en = 1'b0;
        bus.load    = 4'h0;
        bus.down    = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_direction_toggle();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
